periph_access_ctrl: RTL



---
 rtl/periph_access_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/periph_access_ctrl.sv
// periph_access_ctrl: single-outstanding CPU-to-peripheral access bridge.
// Optional watchdog enabled by defining PERIPH_TIMEOUT_EN.
module periph_access_ctrl #(
    parameter int address_width  = 22,
    parameter int data_width     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                CLK,
    input  logic                                RSTn,
    input  logic [address_width-1:0]            CPU_ADDR,
    input  logic [(1<<data_width)*8-1:0]        CPU_WDATA,
    input  logic [(1<<data_width)-1:0]          CPU_BE,
    input  logic                                CPU_RD,
    input  logic                                CPU_WR,
    output logic [(1<<data_width)*8-1:0]        CPU_RDATA,
    output logic                                CPU_DONE,
    output logic                                CPU_ERR,
    output logic                                CPU_BUSY,
    output logic [address_width-1:0]            READ_ADDR,
    input  logic [(1<<data_width)*8-1:0]        DATA_OUT,
    input  logic                                DATA_VALID,
    output logic                                OE,
    output logic [address_width-1:0]            WRITE_ADDR,
    output logic [(1<<data_width)*8-1:0]        DATA_IN,
    output logic [(1<<data_width)-1:0]          BE,
    output logic                                WE,
    input  logic                                WACK
);

    localparam int DW = (1 << data_width) * 8;
    localparam int BW = 1 << data_width;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]               state_q, state_d;
    logic                     oe_q, oe_d;
    logic                     we_q, we_d;
    logic                     done_q, done_d;
    logic [DW-1:0]            rdata_q, rdata_d;
    logic [address_width-1:0] raddr_q, raddr_d;
    logic [address_width-1:0] waddr_q, waddr_d;
    logic [DW-1:0]            wdata_q, wdata_d;
    logic [BW-1:0]            be_q, be_d;

`ifdef PERIPH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Next-state: accept a request while idle, then wait for the response.
    // The strobe cycle itself never carries a response, so it is skipped.
    always_comb begin
        state_d = state_q;
        oe_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
`ifdef PERIPH_TIMEOUT_EN
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (CPU_WR) begin
                    if (|CPU_BE) begin
                        waddr_d = CPU_ADDR;
                        wdata_d = CPU_WDATA;
                        be_d    = CPU_BE;
                        we_d    = 1'b1;
                        state_d = S_WR;
`ifdef PERIPH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        done_d  = 1'b1;
                    end
                end else if (CPU_RD) begin
                    raddr_d = CPU_ADDR;
                    oe_d    = 1'b1;
                    state_d = S_RD;
`ifdef PERIPH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_RD: begin
                if (!oe_q) begin
                    if (DATA_VALID) begin
                        rdata_d = DATA_OUT;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`ifdef PERIPH_TIMEOUT_EN
                    end else if (cnt_q == LIMIT) begin
                        rdata_d = '0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
`endif
                    end
                end
            end
            S_WR: begin
                if (!we_q) begin
                    if (WACK) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`ifdef PERIPH_TIMEOUT_EN
                    end else if (cnt_q == LIMIT) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
`ifdef PERIPH_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
`ifdef PERIPH_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign CPU_RDATA  = rdata_q;
    assign CPU_DONE   = done_q;
    assign CPU_BUSY   = (state_q != S_IDLE);
    assign READ_ADDR  = raddr_q;
    assign OE         = oe_q;
    assign WRITE_ADDR = waddr_q;
    assign DATA_IN    = wdata_q;
    assign BE         = be_q;
    assign WE         = we_q;
`ifdef PERIPH_TIMEOUT_EN
    assign CPU_ERR    = err_q;
`else
    assign CPU_ERR    = 1'b0;
`endif

endmodule
